// File: rtl/rs_bank_oldest_if.sv
// Bus bundle between the issue stage / CDB / functional unit and one
// reservation-station bank.
//  flush        : synchronous clear of every station and the dispatch register
//  issue_*      : issue request, operand tags/values, allocated tag, ready
//  cdb_*        : common data bus broadcast snooped for wakeup and bypass
//  disp_*       : registered dispatch toward the functional unit (valid/ready)
//  busy_vec     : per-station occupancy
// The "slave" modport is the bank; "master" is its environment.
interface rs_bank_oldest_if #(
  parameter int N_RS   = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int OP_W   = 3,
  parameter int AGE_W  = 10
);
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [AGE_W-1:0]  issue_age;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic [DATA_W-1:0] issue_vj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;
  logic [TAG_W-1:0]  disp_tag;
  logic [N_RS-1:0]   busy_vec;

  modport slave (
    input  flush, issue_valid, issue_op, issue_age, issue_qj, issue_qk,
           issue_vj, issue_vk, cdb_valid, cdb_tag, cdb_data, disp_ready,
    output issue_ready, issue_tag, disp_valid, disp_op, disp_vj, disp_vk,
           disp_tag, busy_vec
  );

  modport master (
    output flush, issue_valid, issue_op, issue_age, issue_qj, issue_qk,
           issue_vj, issue_vk, cdb_valid, cdb_tag, cdb_data, disp_ready,
    input  issue_ready, issue_tag, disp_valid, disp_op, disp_vj, disp_vk,
           disp_tag, busy_vec
  );
endinterface

// File: rtl/rs_bank_oldest.sv
// Reservation-station bank with issue-time CDB bypass, CDB snooping wakeup
// and a registered oldest-first dispatch stage feeding one functional unit.
// Ports:
//  CLK  : clock, rising edge
//  CLR  : asynchronous active-low reset
//  bus  : rs_bank_oldest_if.slave (flush, issue, CDB, dispatch, busy_vec)
// Station i owns tag TAG_BASE+i. Tag 0 means "operand value present".
module rs_bank_oldest #(
  parameter int N_RS     = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1,
  parameter int OP_W     = 3,
  parameter int AGE_W    = 10
) (
  input logic             CLK,
  input logic             CLR,
  rs_bank_oldest_if.slave bus
);
  localparam int IDX_W = (N_RS > 1) ? $clog2(N_RS) : 1;

  logic [N_RS-1:0]   busy_r;
  logic [OP_W-1:0]   op_r  [N_RS];
  logic [AGE_W-1:0]  age_r [N_RS];
  logic [TAG_W-1:0]  qj_r  [N_RS];
  logic [TAG_W-1:0]  qk_r  [N_RS];
  logic [DATA_W-1:0] vj_r  [N_RS];
  logic [DATA_W-1:0] vk_r  [N_RS];

  logic              disp_valid_r;
  logic [OP_W-1:0]   disp_op_r;
  logic [DATA_W-1:0] disp_vj_r;
  logic [DATA_W-1:0] disp_vk_r;
  logic [TAG_W-1:0]  disp_tag_r;

  logic              free_found_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic [N_RS-1:0]   ready_s;
  logic              sel_found_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [AGE_W-1:0]  sel_age_s;
  logic              issue_fire_s;
  logic              bypass_j_s;
  logic              bypass_k_s;
  logic              cdb_hit_s;
  logic              disp_load_s;
  logic              disp_take_s;

  // Modular age compare: a is older than b when (a-b) wraps negative.
  function automatic logic is_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction

  // Lowest-index free station, taken from registered busy only
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = 0; i < N_RS; i++) begin
      if (!busy_r[i] && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Oldest ready station; strict compare keeps the lower index on equal ages
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    sel_age_s   = '0;
    for (int i = 0; i < N_RS; i++) begin
      ready_s[i] = busy_r[i] && (qj_r[i] == '0) && (qk_r[i] == '0);
      if (ready_s[i] && (!sel_found_s || is_older(age_r[i], sel_age_s))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        sel_age_s   = age_r[i];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Handshake / bypass qualifiers
  always_comb begin
    issue_fire_s = bus.issue_valid && free_found_s;
    cdb_hit_s    = bus.cdb_valid && (bus.cdb_tag != '0);
    bypass_j_s   = cdb_hit_s && (bus.issue_qj == bus.cdb_tag);
    bypass_k_s   = cdb_hit_s && (bus.issue_qk == bus.cdb_tag);
    disp_load_s  = !disp_valid_r || bus.disp_ready;
    disp_take_s  = disp_load_s && sel_found_s;
  end

  // Station array: issue write with bypass, CDB wakeup, release on dispatch
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      busy_r <= '0;
      for (int i = 0; i < N_RS; i++) begin
        op_r[i]  <= '0;
        age_r[i] <= '0;
        qj_r[i]  <= '0;
        qk_r[i]  <= '0;
        vj_r[i]  <= '0;
        vk_r[i]  <= '0;
      end
    end else if (bus.flush) begin
      busy_r <= '0;
    end else begin
      for (int i = 0; i < N_RS; i++) begin
        if (issue_fire_s && (free_idx_s == IDX_W'(i))) begin
          busy_r[i] <= 1'b1;
          op_r[i]   <= bus.issue_op;
          age_r[i]  <= bus.issue_age;
          qj_r[i]   <= bypass_j_s ? '0 : bus.issue_qj;
          qk_r[i]   <= bypass_k_s ? '0 : bus.issue_qk;
          vj_r[i]   <= bypass_j_s ? bus.cdb_data : bus.issue_vj;
          vk_r[i]   <= bypass_k_s ? bus.cdb_data : bus.issue_vk;
        end else begin
          if (disp_take_s && (sel_idx_s == IDX_W'(i))) begin
            busy_r[i] <= 1'b0;
          end
          // qj_r==cdb_tag with cdb_tag nonzero implies a real pending dependency
          if (cdb_hit_s && busy_r[i] && (qj_r[i] == bus.cdb_tag)) begin
            qj_r[i] <= '0;
            vj_r[i] <= bus.cdb_data;
          end
          if (cdb_hit_s && busy_r[i] && (qk_r[i] == bus.cdb_tag)) begin
            qk_r[i] <= '0;
            vk_r[i] <= bus.cdb_data;
          end
        end
      end
    end
  end

  // Dispatch register: refills when empty or when the FU takes the current op
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      disp_valid_r <= 1'b0;
      disp_op_r    <= '0;
      disp_vj_r    <= '0;
      disp_vk_r    <= '0;
      disp_tag_r   <= '0;
    end else if (bus.flush) begin
      disp_valid_r <= 1'b0;
      disp_op_r    <= '0;
      disp_vj_r    <= '0;
      disp_vk_r    <= '0;
      disp_tag_r   <= '0;
    end else if (disp_load_s) begin
      disp_valid_r <= sel_found_s;
      if (sel_found_s) begin
        disp_op_r  <= op_r[sel_idx_s];
        disp_vj_r  <= vj_r[sel_idx_s];
        disp_vk_r  <= vk_r[sel_idx_s];
        disp_tag_r <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx_s);
      end
    end
  end

  assign bus.issue_ready = free_found_s;
  assign bus.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx_s);
  assign bus.busy_vec    = busy_r;
  assign bus.disp_valid  = disp_valid_r;
  assign bus.disp_op     = disp_op_r;
  assign bus.disp_vj     = disp_vj_r;
  assign bus.disp_vk     = disp_vk_r;
  assign bus.disp_tag    = disp_tag_r;
endmodule

// File: tb/tb_rs_bank_oldest.sv
// Self-checking bench for rs_bank_oldest: directed scenarios followed by
// random traffic, checked against a behavioural model of the station bank.
// Expected dispatches go into a queue; a monitor pops them on handshakes.
module tb_rs_bank_oldest;
  localparam int N_RS = 4, DATA_W = 16, TAG_W = 3, TAG_BASE = 1, OP_W = 3, AGE_W = 10;
  localparam int AGE_MOD = 1 << AGE_W;

  logic CLK;
  logic CLR;

  rs_bank_oldest_if #(.N_RS(N_RS), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .AGE_W(AGE_W)) bus ();

  rs_bank_oldest #(.N_RS(N_RS), .DATA_W(DATA_W), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE),
                   .OP_W(OP_W), .AGE_W(AGE_W)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { bit busy; int op; int age; int qj; int qk; int vj; int vk; } mst_t;
  typedef struct { int op; int vj; int vk; int tag; } disp_t;

  mst_t  ms [N_RS];
  bit    m_dv;
  disp_t exp_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  int    age_cnt = 0;
  int    last_tag = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit older(input int a, input int b);
    return ((a - b) & (AGE_MOD - 1)) >= (AGE_MOD / 2);
  endfunction

  function automatic bit m_ready(input int i);
    return ms[i].busy && ms[i].qj == 0 && ms[i].qk == 0;
  endfunction

  // Oldest ready station: nobody ready is older, ties go to the lower index
  function automatic int m_pick();
    for (int i = 0; i < N_RS; i++) begin
      if (m_ready(i)) begin
        bit beaten = 1'b0;
        for (int k = 0; k < N_RS; k++)
          if (k != i && m_ready(k) && (older(ms[k].age, ms[i].age) || (ms[k].age == ms[i].age && k < i)))
            beaten = 1'b1;
        if (!beaten) return i;
      end
    end
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < N_RS; i++) if (!ms[i].busy) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_RS; i++) ms[i].busy = 1'b0;
    m_dv = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model across one clock edge using the currently driven inputs
  task automatic model_step();
    int f, b, ct, cd;
    f = m_free();
    if (bus.flush) begin
      m_reset();
      return;
    end
    b = m_pick();
    if (!m_dv || bus.disp_ready) begin
      if (b >= 0) begin
        m_dv = 1'b1;
        exp_q.push_back('{ms[b].op, ms[b].vj, ms[b].vk, TAG_BASE + b});
        ms[b].busy = 1'b0;
      end else begin
        m_dv = 1'b0;
      end
    end
    ct = int'(bus.cdb_tag);
    cd = int'(bus.cdb_data);
    if (bus.cdb_valid && ct != 0) begin
      for (int i = 0; i < N_RS; i++) if (ms[i].busy) begin
        if (ms[i].qj == ct) begin ms[i].qj = 0; ms[i].vj = cd; end
        if (ms[i].qk == ct) begin ms[i].qk = 0; ms[i].vk = cd; end
      end
    end
    if (bus.issue_valid && f >= 0) begin
      ms[f].busy = 1'b1;
      ms[f].op   = int'(bus.issue_op);
      ms[f].age  = int'(bus.issue_age);
      ms[f].qj   = int'(bus.issue_qj);
      ms[f].qk   = int'(bus.issue_qk);
      ms[f].vj   = int'(bus.issue_vj);
      ms[f].vk   = int'(bus.issue_vk);
      if (bus.cdb_valid && ct != 0 && ms[f].qj == ct) begin ms[f].qj = 0; ms[f].vj = cd; end
      if (bus.cdb_valid && ct != 0 && ms[f].qk == ct) begin ms[f].qk = 0; ms[f].vk = cd; end
      age_cnt++;
    end
  endtask

  // Called at a negedge with inputs applied; compares, steps model, ends at next negedge
  task automatic step();
    int f, bv;
    #1;
    f = m_free();
    bv = 0;
    for (int i = 0; i < N_RS; i++) if (ms[i].busy) bv |= (1 << i);
    chk("issue_ready", int'(bus.issue_ready), (f >= 0) ? 1 : 0);
    if (f >= 0) chk("issue_tag", int'(bus.issue_tag), TAG_BASE + f);
    chk("busy_vec", int'(bus.busy_vec), bv);
    chk("disp_valid", int'(bus.disp_valid), int'(m_dv));
    last_tag = int'(bus.issue_tag);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic iss(input int op, input int age, input int qj, input int qk, input int vj, input int vk);
    bus.issue_valid = 1'b1;
    bus.issue_op    = OP_W'(op);
    bus.issue_age   = AGE_W'(age);
    bus.issue_qj    = TAG_W'(qj);
    bus.issue_qk    = TAG_W'(qk);
    bus.issue_vj    = DATA_W'(vj);
    bus.issue_vk    = DATA_W'(vk);
  endtask

  task automatic cdb(input int tag, input int data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = TAG_W'(tag);
    bus.cdb_data  = DATA_W'(data);
  endtask

  task automatic rand_cycle(input int cyc);
    bus.issue_valid = ($urandom_range(0, 99) < 60);
    bus.issue_op    = OP_W'($urandom_range(0, 7));
    bus.issue_age   = AGE_W'(age_cnt % AGE_MOD);
    bus.issue_qj    = $urandom_range(0, 1) ? TAG_W'(0) : TAG_W'($urandom_range(1, 7));
    bus.issue_qk    = $urandom_range(0, 1) ? TAG_W'(0) : TAG_W'($urandom_range(1, 7));
    bus.issue_vj    = DATA_W'($urandom);
    bus.issue_vk    = DATA_W'($urandom);
    bus.cdb_valid   = ($urandom_range(0, 1) == 1);
    bus.cdb_tag     = TAG_W'($urandom_range(0, 7));
    bus.cdb_data    = DATA_W'($urandom);
    bus.flush       = (cyc % 97 == 96);
    bus.disp_ready  = bus.flush ? 1'b0 : ($urandom_range(0, 99) < 70);
    step();
  endtask

  // Monitor: each handshake must present the next expected dispatch
  initial begin : monitor
    disp_t d;
    forever begin
      @(negedge CLK);
      #2;
      if (CLR && bus.disp_valid && bus.disp_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          chk("disp_unexpected", int'(bus.disp_tag), -1);
        end else begin
          d = exp_q.pop_front();
          chk("disp_op", int'(bus.disp_op), d.op);
          chk("disp_vj", int'(bus.disp_vj), d.vj);
          chk("disp_vk", int'(bus.disp_vk), d.vk);
          chk("disp_tag", int'(bus.disp_tag), d.tag);
        end
      end
    end
  end

  initial begin : stim
    CLR = 1'b0;
    idle();
    iss(0, 0, 0, 0, 0, 0);
    bus.issue_valid = 1'b0;
    cdb(0, 0);
    bus.cdb_valid  = 1'b0;
    bus.disp_ready = 1'b0;
    m_reset();
    repeat (3) @(negedge CLK);
    chk("rst_disp_valid", int'(bus.disp_valid), 0);
    chk("rst_busy_vec", int'(bus.busy_vec), 0);
    chk("rst_issue_ready", int'(bus.issue_ready), 1);
    chk("rst_disp_vj", int'(bus.disp_vj), 0);
    CLR = 1'b1;
    @(negedge CLK);

    // Ready-at-issue op dispatches at the following edge
    bus.disp_ready = 1'b1;
    iss(1, 7, 0, 0, 5, 3);
    step();
    chk("t2_tag", last_tag, 1);
    chk("t2_not_yet", int'(bus.disp_valid), 0);
    idle();
    step();
    chk("t2_valid", int'(bus.disp_valid), 1);
    chk("t2_vj", int'(bus.disp_vj), 5);
    chk("t2_vk", int'(bus.disp_vk), 3);
    chk("t2_dtag", int'(bus.disp_tag), 1);

    // CDB wakeup on qj
    iss(2, 8, 2, 0, 0, 4);
    step();
    idle();
    cdb(2, 'h00AA);
    step();
    chk("t3_wait", int'(bus.disp_valid), 0);
    idle();
    step();
    chk("t3_valid", int'(bus.disp_valid), 1);
    chk("t3_vj", int'(bus.disp_vj), 'h00AA);

    // Issue-time bypass on qk
    iss(3, 9, 0, 3, 7, 0);
    cdb(3, 9);
    step();
    idle();
    step();
    chk("t4_valid", int'(bus.disp_valid), 1);
    chk("t4_vk", int'(bus.disp_vk), 9);
    chk("t4_vj", int'(bus.disp_vj), 7);

    // Wrapping ages woken together dispatch as 1022, 1023, 2
    iss(4, 2, 5, 0, 1, 1);    step();
    iss(4, 1023, 5, 0, 2, 2); step();
    iss(4, 1022, 5, 0, 3, 3); step();
    idle();
    cdb(5, 'h55);
    step();
    idle();
    step();
    chk("t5_first", int'(bus.disp_tag), 3);
    step();
    chk("t5_second", int'(bus.disp_tag), 2);
    step();
    chk("t5_third", int'(bus.disp_tag), 1);

    // Fill every station, then issue must be ignored
    bus.disp_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (!bus.issue_ready) break;
      iss(5, 20 + n, 6, 0, n, n);
      step();
    end
    chk("t6_full_ready", int'(bus.issue_ready), 0);
    chk("t6_full_busy", int'(bus.busy_vec), 'hF);
    iss(6, 40, 0, 0, 1, 1);
    step();
    chk("t6_ignored", int'(bus.busy_vec), 'hF);

    // Flush clears stations and dispatch register
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t7_busy", int'(bus.busy_vec), 0);
    chk("t7_valid", int'(bus.disp_valid), 0);
    chk("t7_ready", int'(bus.issue_ready), 1);

    // Random traffic with wrapping ages
    age_cnt = 1000;
    for (int c = 0; c < 1500; c++) rand_cycle(c);

    // Asynchronous reset in the middle of traffic
    idle();
    bus.disp_ready = 1'b0;
    #3;
    CLR = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.disp_valid), 0);
    chk("mid_rst_busy", int'(bus.busy_vec), 0);
    chk("mid_rst_ready", int'(bus.issue_ready), 1);
    m_reset();
    @(negedge CLK);
    CLR = 1'b1;

    for (int c = 0; c < 1500; c++) rand_cycle(c);

    // Drain whatever can still complete
    idle();
    bus.disp_ready = 1'b1;
    repeat (10) step();
    chk("drain_queue", exp_q.size(), m_dv ? 1 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
